// File: rtl/reg_file_wb.sv
// 32x32 register file with an in-order write-back queue; commits one head entry per drain cycle (min 1 cycle accept-to-array).
// wb_ready is a pure function of queue occupancy; define WB_BYPASS_EN to forward pending writes to the read ports.
module reg_file_wb #(
  parameter int WB_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_valid,
  output logic                      wb_ready,
  input  logic [4:0]                wb_rd,
  input  logic [31:0]               wb_data,
  input  logic                      drain,
  input  logic [4:0]                rs1,
  input  logic [4:0]                rs2,
  output logic [31:0]               rd1,
  output logic [31:0]               rd2,
  output logic                      hazard,
  output logic [$clog2(WB_DEPTH):0] wb_count,
  output logic                      wb_idle
);
  localparam int PW = $clog2(WB_DEPTH);

  logic [31:0]   regs   [32];
  logic [4:0]    q_rd   [WB_DEPTH];
  logic [31:0]   q_data [WB_DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic          push, pop;

  assign wb_ready = count < (PW+1)'(WB_DEPTH);
  assign wb_idle  = (count == '0);
  assign wb_count = count;
  // x0 writes complete the handshake but never occupy a slot
  assign push = wb_valid && wb_ready && (wb_rd != 5'd0);
  assign pop  = drain && !wb_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (pop) begin
        regs[q_rd[head]] <= q_data[head];
        head <= head + PW'(1);
      end
      if (push) tail <= tail + PW'(1);
      if (push && !pop)
        count <= count + (PW+1)'(1);
      else if (pop && !push)
        count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail]   <= wb_rd;
      q_data[tail] <= wb_data;
    end
  end

  logic [31:0]   arr1, arr2;
  logic          hit1, hit2;
  logic [PW-1:0] ptr;

  assign arr1 = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign arr2 = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    ptr  = head;
    for (int i = 0; i < WB_DEPTH; i++) begin
      ptr = head + PW'(i);
      if ((PW+1)'(i) < count) begin
        if (rs1 != 5'd0 && q_rd[ptr] == rs1) hit1 = 1'b1;
        if (rs2 != 5'd0 && q_rd[ptr] == rs2) hit2 = 1'b1;
      end
    end
  end

`ifdef WB_BYPASS_EN
  logic [31:0]   fwd1, fwd2;
  logic [PW-1:0] bptr;

  // Scan oldest to youngest so the youngest matching entry wins
  always_comb begin
    fwd1 = '0;
    fwd2 = '0;
    bptr = head;
    for (int i = 0; i < WB_DEPTH; i++) begin
      bptr = head + PW'(i);
      if ((PW+1)'(i) < count) begin
        if (q_rd[bptr] == rs1) fwd1 = q_data[bptr];
        if (q_rd[bptr] == rs2) fwd2 = q_data[bptr];
      end
    end
  end

  assign rd1    = hit1 ? fwd1 : arr1;
  assign rd2    = hit2 ? fwd2 : arr2;
  assign hazard = 1'b0;
`else
  assign rd1    = arr1;
  assign rd2    = arr2;
  assign hazard = hit1 | hit2;
`endif

endmodule

// File: tb/tb_reg_file_wb.sv
// Randomised and directed bench for reg_file_wb against a queue-plus-array reference model.
module tb_reg_file_wb;
  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        drain = 1'b0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] rd1, rd2;
  logic        hazard;
  logic [1:0]  wb_count;
  logic        wb_idle;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [32];
  ent_t        q [$];

  reg_file_wb #(.WB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .drain(drain), .rs1(rs1), .rs2(rs2),
    .rd1(rd1), .rd2(rd2), .hazard(hazard), .wb_count(wb_count), .wb_idle(wb_idle)
  );

  always #5 clk = ~clk;

  // Advance one clock, applying the architectural rules to the model from pre-edge inputs.
  task automatic cycle();
    bit acc, pp;
    acc = wb_valid && (q.size() < DEPTH);
    pp  = drain && (q.size() != 0);
    @(posedge clk);
    if (rst) begin
      q.delete();
      foreach (mdl[i]) mdl[i] = '0;
    end else begin
      if (pp) begin
        mdl[q[0].rd] = q[0].data;
        void'(q.pop_front());
      end
      if (acc && wb_rd != 5'd0) q.push_back('{wb_rd, wb_data});
    end
    #1;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    logic [31:0] v;
    if (idx == 5'd0) return 32'd0;
    v = mdl[idx];
`ifdef WB_BYPASS_EN
    foreach (q[i]) if (q[i].rd == idx) v = q[i].data;
`endif
    return v;
  endfunction

  function automatic logic exp_hazard(input logic [4:0] a, input logic [4:0] b);
`ifdef WB_BYPASS_EN
    return 1'b0;
`else
    foreach (q[i])
      if ((a != 5'd0 && q[i].rd == a) || (b != 5'd0 && q[i].rd == b)) return 1'b1;
    return 1'b0;
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1; drain = 1'b1;
    cycle(); cycle();
    rst = 1'b0; drain = 1'b0;
    #1;
    checks++;
    if (wb_count !== 2'd0 || wb_idle !== 1'b1 || wb_ready !== 1'b1 || hazard !== 1'b0) begin
      errors++;
      $display("FAIL reset_status count=%0d idle=%b ready=%b hazard=%b exp 0/1/1/0", wb_count, wb_idle, wb_ready, hazard);
    end
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      checks++;
      if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
        errors++;
        $display("FAIL reset_read idx=%0d rd1=%h rd2=%h exp 0", i, rd1, rd2);
      end
    end
  endtask

  task automatic test_basic_write();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF; drain = 1'b1;
    cycle();
    wb_valid = 1'b0;
    checks++;
    if (wb_count !== 2'd1) begin
      errors++;
      $display("FAIL basic_queued count=%0d exp 1", wb_count);
    end
    cycle();
    drain = 1'b0; rs1 = 5'd5;
    #1;
    checks++;
    if (rd1 !== 32'hDEADBEEF || wb_idle !== 1'b1) begin
      errors++;
      $display("FAIL basic_commit rd1=%h idle=%b exp deadbeef/1", rd1, wb_idle);
    end
  endtask

  task automatic test_x0();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234; drain = 1'b0;
    cycle();
    wb_valid = 1'b0; rs2 = 5'd0;
    #1;
    checks++;
    if (wb_count !== 2'd0 || rd2 !== 32'd0 || wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_write count=%0d rd2=%h ready=%b exp 0/0/1", wb_count, rd2, wb_ready);
    end
  endtask

  task automatic test_backpressure();
    drain = 1'b0; wb_valid = 1'b1;
    wb_rd = 5'd3; wb_data = 32'h11; cycle();
    wb_rd = 5'd4; wb_data = 32'h22; cycle();
    checks++;
    if (wb_ready !== 1'b0 || wb_count !== 2'd2) begin
      errors++;
      $display("FAIL bp_full ready=%b count=%0d exp 0/2", wb_ready, wb_count);
    end
    wb_rd = 5'd6; wb_data = 32'h33; cycle();
    checks++;
    if (wb_count !== 2'd2) begin
      errors++;
      $display("FAIL bp_refuse count=%0d exp 2", wb_count);
    end
    drain = 1'b1; cycle();
    rs1 = 5'd3; rs2 = 5'd6; #1;
    checks++;
    if (rd1 !== 32'h11 || wb_count !== 2'd1 || rd2 !== exp_read(5'd6)) begin
      errors++;
      $display("FAIL bp_first_commit rd1=%h count=%0d rd2=%h exp 11/1/%h", rd1, wb_count, rd2, exp_read(5'd6));
    end
    cycle();
    wb_valid = 1'b0;
    rs1 = 5'd4; #1;
    checks++;
    if (rd1 !== 32'h22 || wb_count !== 2'd1) begin
      errors++;
      $display("FAIL bp_second_commit rd1=%h count=%0d exp 22/1", rd1, wb_count);
    end
    cycle();
    drain = 1'b0; rs1 = 5'd6; #1;
    checks++;
    if (rd1 !== 32'h33 || wb_idle !== 1'b1) begin
      errors++;
      $display("FAIL bp_late_accept rd1=%h idle=%b exp 33/1", rd1, wb_idle);
    end
  endtask

  task automatic test_same_rd();
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77; drain = 1'b1;
    cycle();
    wb_valid = 1'b0; cycle();
    drain = 1'b0; wb_valid = 1'b1;
    wb_data = 32'hA; cycle();
    wb_data = 32'hB; cycle();
    wb_valid = 1'b0; rs1 = 5'd7; rs2 = 5'd0; #1;
    checks++;
`ifdef WB_BYPASS_EN
    if (rd1 !== 32'hB || hazard !== 1'b0) begin
      errors++;
      $display("FAIL same_rd_pending rd1=%h hazard=%b exp b/0", rd1, hazard);
    end
`else
    if (rd1 !== 32'h77 || hazard !== 1'b1) begin
      errors++;
      $display("FAIL same_rd_pending rd1=%h hazard=%b exp 77/1", rd1, hazard);
    end
`endif
    drain = 1'b1; cycle(); cycle();
    drain = 1'b0; #1;
    checks++;
    if (rd1 !== 32'hB || hazard !== 1'b0 || wb_idle !== 1'b1) begin
      errors++;
      $display("FAIL same_rd_drained rd1=%h hazard=%b idle=%b exp b/0/1", rd1, hazard, wb_idle);
    end
  endtask

  task automatic test_reset_mid();
    drain = 1'b0; wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h55;
    cycle();
    wb_valid = 1'b0; rst = 1'b1; drain = 1'b1;
    cycle();
    rst = 1'b0; drain = 1'b0; rs1 = 5'd9; rs2 = 5'd5; #1;
    checks++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0 || wb_count !== 2'd0 || wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid rd1=%h rd2=%h count=%0d ready=%b exp 0/0/0/1", rd1, rd2, wb_count, wb_ready);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 99) == 0);
      wb_valid = $urandom_range(0, 1) == 1;
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      drain    = $urandom_range(0, 2) != 0;
      rs1      = 5'($urandom_range(0, 7));
      rs2      = 5'($urandom_range(0, 7));
      #1;
      checks++;
      if (rd1 !== exp_read(rs1) || rd2 !== exp_read(rs2) || hazard !== exp_hazard(rs1, rs2) ||
          wb_count !== 2'(q.size()) || wb_ready !== (q.size() < DEPTH) || wb_idle !== (q.size() == 0)) begin
        errors++;
        $display("FAIL random n=%0d rs=%0d/%0d rd=%h/%h exp %h/%h hz=%b exp %b cnt=%0d exp %0d",
                 n, rs1, rs2, rd1, rd2, exp_read(rs1), exp_read(rs2), hazard, exp_hazard(rs1, rs2),
                 wb_count, q.size());
      end
      cycle();
    end
    rst = 1'b0; wb_valid = 1'b0; drain = 1'b1;
    cycle(); cycle(); cycle();
    drain = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); #1;
      checks++;
      if (rd1 !== mdl[i] && i != 0) begin
        errors++;
        $display("FAIL final_array x%0d got %h exp %h", i, rd1, mdl[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_x0();
    test_backpressure();
    test_same_rd();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
